// File: rtl/matrix_d_writeback_pkg.sv
// Shared definitions for the matrix-D result writeback path.
//  WB_LANES   lanes per io_out bundle
//  WB_LANE_W  bits per lane (matrix_d_data width)
//  WB_DEPTH   bundle FIFO entries (power of 2, >= 2)
//  WB_ADDR_W  result-RF word address width
//  WB_DONE_W  width of the completed-bundle counter
//  lane_e     lane order inside a bundle; the enum value is the lane index k,
//             i.e. the slice in_data[k*WB_LANE_W +: WB_LANE_W]
//  wb_state_e writeback FSM states
package matrix_d_writeback_pkg;

   localparam int WB_LANES  = 8;
   localparam int WB_LANE_W = 64;
   localparam int WB_DEPTH  = 2;
   localparam int WB_ADDR_W = 8;
   localparam int WB_DONE_W = 16;

   typedef enum logic [2:0] {
      TC0_OCT0_TG0 = 3'd0,
      TC0_OCT0_TG4 = 3'd1,
      TC0_OCT1_TG0 = 3'd2,
      TC0_OCT1_TG4 = 3'd3,
      TC1_OCT0_TG0 = 3'd4,
      TC1_OCT0_TG4 = 3'd5,
      TC1_OCT1_TG0 = 3'd6,
      TC1_OCT1_TG4 = 3'd7
   } lane_e;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } wb_state_e;

endpackage

// File: rtl/matrix_d_writeback_bundle_fifo.sv
// Bundle FIFO: DEPTH entries of W bits, read/write pointers plus occupancy count.
//  clock, reset   rising-edge clock, asynchronous active-high reset
//  flush          synchronous clear, wins over a same-cycle push/pop
//  push/push_data write push_data at the tail (caller never pushes when full)
//  pop            drop the head entry (caller never pops when empty)
//  head_data      current head entry
//  full/empty     occupancy flags derived from the registered count
//  count          number of stored entries
module matrix_d_writeback_bundle_fifo #(
   parameter int W     = 512,
   parameter int DEPTH = 2
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage carries no reset: an entry is only observed after it was written.
   always_ff @(posedge clock) begin
      if (push && !flush) mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   assign head_data = mem[rd_ptr];
   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);

endmodule

// File: rtl/matrix_d_writeback.sv
// Matrix-D writeback: accepts one io_out result bundle per valid/ready handshake
// into a small FIFO and serializes each bundle into LANES single-lane RF writes.
//  clock, reset   rising-edge clock, asynchronous active-high reset
//  flush          synchronous clear of FIFO, FSM, lane index, address counter
//  in_valid/in_ready/in_data   bundle input from the System (lane k at [k*LANE_W +: LANE_W])
//  wr_valid/wr_ready/wr_addr/wr_data   single-lane RF write port
//  bundles_done   count of fully written bundles (wraps)
//  busy           FIFO non-empty or drain in progress
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. valid never depends on ready; once wr_valid is raised, wr_valid, wr_addr
// and wr_data stay stable until the lane is accepted. in_ready depends only on
// registered FIFO occupancy, never on in_valid or wr_ready.
module matrix_d_writeback
   import matrix_d_writeback_pkg::*;
#(
   parameter int LANES  = WB_LANES,
   parameter int LANE_W = WB_LANE_W,
   parameter int DEPTH  = WB_DEPTH,
   parameter int ADDR_W = WB_ADDR_W
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*LANE_W-1:0] in_data,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [LANE_W-1:0]       wr_data,
   output logic [WB_DONE_W-1:0]    bundles_done,
   output logic                    busy
);

   localparam int IDX_W = $clog2(LANES);
   localparam int CNT_W = $clog2(DEPTH+1);

   wb_state_e               state;
   logic [IDX_W-1:0]        lane_idx;
   logic [ADDR_W-1:0]       addr_ctr;
   logic [LANES*LANE_W-1:0] head_data;
   logic [LANE_W-1:0]       lane_word;
   logic [CNT_W-1:0]        fifo_count;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    push;
   logic                    last_lane;
   logic                    pop;
   logic                    more_bundles;

   assign in_ready  = !fifo_full;
   assign push      = in_valid && in_ready;
   assign last_lane = (lane_idx == IDX_W'(LANES-1));
   assign pop       = (state == ST_DRAIN) && wr_ready && last_lane;
   // After the final-lane pop, another bundle is present if one was queued
   // behind the head or arrives on this same edge; keep draining without a bubble.
   assign more_bundles = (fifo_count > CNT_W'(1)) || push;

   matrix_d_writeback_bundle_fifo #(
      .W     (LANES*LANE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .flush     (flush),
      .push      (push),
      .push_data (in_data),
      .pop       (pop),
      .head_data (head_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      lane_word = '0;
      for (int k = 0; k < LANES; k++) begin
         if (lane_idx == IDX_W'(k)) lane_word = head_data[k*LANE_W +: LANE_W];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         lane_idx     <= '0;
         addr_ctr     <= '0;
         bundles_done <= '0;
      end else if (flush) begin
         state        <= ST_IDLE;
         lane_idx     <= '0;
         addr_ctr     <= '0;
         bundles_done <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!fifo_empty) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (wr_ready) begin
                  addr_ctr <= addr_ctr + 1'b1;
                  if (last_lane) begin
                     lane_idx     <= '0;
                     bundles_done <= bundles_done + 1'b1;
                     if (!more_bundles) state <= ST_IDLE;
                  end else begin
                     lane_idx <= lane_idx + 1'b1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode registered state only; wr_data is forced to zero when idle
   // so the unreset FIFO storage never reaches the port.
   assign wr_valid = (state == ST_DRAIN);
   assign wr_addr  = addr_ctr;
   assign wr_data  = wr_valid ? lane_word : '0;
   assign busy     = !fifo_empty || (state == ST_DRAIN);

endmodule

// File: tb/tb_matrix_d_writeback.sv
// Bench for matrix_d_writeback: bundle driver, scoreboard of expected
// {addr, data} RF writes, and one task per scenario.
module tb_matrix_d_writeback;
   import matrix_d_writeback_pkg::*;

   localparam int BW = WB_LANES*WB_LANE_W;
   localparam int EW = WB_ADDR_W + WB_LANE_W;

   logic                   clock;
   logic                   reset;
   logic                   flush;
   logic                   in_valid;
   logic                   in_ready;
   logic [BW-1:0]          in_data;
   logic                   wr_valid;
   logic                   wr_ready;
   logic [WB_ADDR_W-1:0]   wr_addr;
   logic [WB_LANE_W-1:0]   wr_data;
   logic [WB_DONE_W-1:0]   bundles_done;
   logic                   busy;

   matrix_d_writeback dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .bundles_done (bundles_done),
      .busy         (busy)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required test completion");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   logic [EW-1:0]          exp_q[$];
   logic [WB_ADDR_W-1:0]   exp_addr;
   logic [WB_DONE_W-1:0]   exp_done;
   int                     n_checks;
   int                     n_fail;
   int                     n_acc;
   int                     n_holds;
   logic [EW-1:0]          mon_e;
   logic                   held_valid;
   logic [WB_ADDR_W-1:0]   held_addr;
   logic [WB_LANE_W-1:0]   held_data;
   logic [WB_ADDR_W-1:0]   last_addr;
   logic                   have_last;
   logic                   saw_wrap;
   logic                   stall_done;

   // Every accepted write is popped against the expected queue; a stalled
   // write must be presented unchanged on the next cycle.
   always @(negedge clock) begin
      if (wr_valid && wr_ready) begin
         n_acc++;
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== mon_e) begin
               n_fail++;
               $display("FAIL write_value: got addr=%0d data=%h, required addr=%0d data=%h",
                        wr_addr, wr_data, mon_e[EW-1:WB_LANE_W], mon_e[WB_LANE_W-1:0]);
            end
         end
         if (have_last && last_addr == 8'hff && wr_addr == 8'h00) saw_wrap = 1'b1;
         last_addr = wr_addr;
         have_last = 1'b1;
      end
      if (held_valid) begin
         n_checks++;
         if (wr_valid !== 1'b1 || wr_addr !== held_addr || wr_data !== held_data) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                     wr_valid, wr_addr, wr_data, held_addr, held_data);
         end
      end
      held_valid = wr_valid && !wr_ready && !reset && !flush;
      held_addr  = wr_addr;
      held_data  = wr_data;
      if (held_valid) n_holds++;
   end

   // ---------------- driver tasks ----------------
   task automatic enqueue_exp(input logic [BW-1:0] d);
      for (int k = 0; k < WB_LANES; k++) begin
         exp_q.push_back({exp_addr, d[k*WB_LANE_W +: WB_LANE_W]});
         exp_addr = exp_addr + 1'b1;
      end
      exp_done = exp_done + 1'b1;
   endtask

   function automatic logic [BW-1:0] rand_bundle();
      logic [BW-1:0] d;
      for (int k = 0; k < WB_LANES; k++) d[k*WB_LANE_W +: WB_LANE_W] = {$urandom, $urandom};
      return d;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the handshake edge.
   task automatic push_bundle(input logic [BW-1:0] d, output int waited);
      in_valid = 1'b1;
      in_data  = d;
      waited   = 0;
      @(negedge clock);
      while (!in_ready && waited < 1000) begin
         waited++;
         @(negedge clock);
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: in_ready stayed %b, required 1", in_ready);
      end else begin
         enqueue_exp(d);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      @(negedge clock);
      while (busy && c < budget) begin
         c++;
         @(negedge clock);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_timeout: busy=%b after %0d cycles, required 0", busy, budget);
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_writes: %0d writes outstanding, required 0", exp_q.size());
      end
      @(posedge clock);
      #1;
   endtask

   task automatic wait_accepts(input int base, input int n);
      int c = 0;
      @(negedge clock);
      #1;
      while ((n_acc - base) < n && c < 200) begin
         c++;
         @(negedge clock);
         #1;
      end
      n_checks++;
      if ((n_acc - base) < n) begin
         n_fail++;
         $display("FAIL accept_timeout: got %0d accepts, required %0d", n_acc - base, n);
      end
   endtask

   task automatic clear_model();
      exp_q.delete();
      exp_addr = '0;
      exp_done = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
      n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid: got %b, required 0", wr_valid); end
      n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr: got %0d, required 0", wr_addr); end
      n_checks++; if (wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data: got %h, required 0", wr_data); end
      n_checks++; if (bundles_done !== '0) begin n_fail++; $display("FAIL reset_bundles_done: got %0d, required 0", bundles_done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_single();
      logic [BW-1:0] d;
      int w;
      for (int k = 0; k < WB_LANES; k++) d[k*WB_LANE_W +: WB_LANE_W] = 64'h1000 + 64'(k);
      push_bundle(d, w);
      @(negedge clock);
      n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_latency_early: wr_valid=%b, required 0", wr_valid); end
      @(negedge clock);
      for (int i = 0; i < WB_LANES; i++) begin
         n_checks++;
         if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL single_consecutive: lane %0d wr_valid=%b, required 1", i, wr_valid); end
         @(negedge clock);
      end
      n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL single_end: wr_valid=%b, required 0", wr_valid); end
      wait_idle(50);
      n_checks++; if (bundles_done !== exp_done) begin n_fail++; $display("FAIL single_done: got %0d, required %0d", bundles_done, exp_done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b, required 0", busy); end
   endtask

   task automatic test_back_to_back();
      int w0, w1, w2, run;
      fork
         begin
            push_bundle(rand_bundle(), w0);
            push_bundle(rand_bundle(), w1);
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: in_ready=%b, required 0", in_ready); end
            push_bundle(rand_bundle(), w2);
         end
         begin
            int c = 0;
            @(negedge clock);
            while (!wr_valid && c < 50) begin c++; @(negedge clock); end
            run = 0;
            while (wr_valid && run < 100) begin run++; @(negedge clock); end
         end
      join
      n_checks++; if (w2 != WB_LANES) begin n_fail++; $display("FAIL b2b_in_ready_low: low for %0d cycles, required %0d", w2, WB_LANES); end
      wait_idle(100);
      n_checks++; if (run != 3*WB_LANES) begin n_fail++; $display("FAIL b2b_bubble: %0d contiguous writes, required %0d", run, 3*WB_LANES); end
      n_checks++; if (bundles_done !== exp_done) begin n_fail++; $display("FAIL b2b_done: got %0d, required %0d", bundles_done, exp_done); end
   endtask

   task automatic test_stall();
      int w;
      int holds0 = n_holds;
      stall_done = 1'b0;
      fork
         begin
            push_bundle(rand_bundle(), w);
            push_bundle(rand_bundle(), w);
            wait_idle(300);
            stall_done = 1'b1;
         end
         begin
            int idx = 0;
            while (!stall_done) begin
               wr_ready = (idx % 3 == 0);
               idx++;
               @(posedge clock);
               #1;
            end
         end
      join
      wr_ready = 1'b1;
      n_checks++; if (n_holds == holds0) begin n_fail++; $display("FAIL stall_seen: got %0d stalled cycles, required >0", n_holds - holds0); end
      n_checks++; if (bundles_done !== exp_done) begin n_fail++; $display("FAIL stall_done: got %0d, required %0d", bundles_done, exp_done); end
   endtask

   // Streams enough bundles from address 0 to run the address counter through 255 -> 0.
   task automatic test_addr_wrap();
      int w;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      clear_model();
      saw_wrap = 1'b0;
      for (int b = 0; b < 33; b++) push_bundle(rand_bundle(), w);
      wait_idle(100);
      n_checks++; if (saw_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_seen: got %b, required 1", saw_wrap); end
      n_checks++; if (wr_addr !== 8'd8) begin n_fail++; $display("FAIL wrap_addr: got %0d, required 8", wr_addr); end
      n_checks++; if (bundles_done !== exp_done) begin n_fail++; $display("FAIL wrap_done: got %0d, required %0d", bundles_done, exp_done); end
   endtask

   task automatic test_reset_mid();
      int w;
      int base;
      // asynchronous reset after lane 3 of a bundle
      base = n_acc;
      push_bundle(rand_bundle(), w);
      wait_accepts(base, 4);
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_wr_valid: got %b, required 0", wr_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b, required 1", in_ready); end
      n_checks++; if (bundles_done !== '0) begin n_fail++; $display("FAIL rst_mid_done: got %0d, required 0", bundles_done); end
      n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL rst_mid_addr: got %0d, required 0", wr_addr); end
      clear_model();
      @(posedge clock);
      #1;
      reset = 1'b0;
      push_bundle(rand_bundle(), w);
      wait_idle(50);
      n_checks++; if (bundles_done !== exp_done) begin n_fail++; $display("FAIL rst_after_done: got %0d, required %0d", bundles_done, exp_done); end
      // synchronous flush at the same point
      base = n_acc;
      push_bundle(rand_bundle(), w);
      wait_accepts(base, 4);
      @(posedge clock);
      #1;
      flush    = 1'b1;
      wr_ready = 1'b0;
      #1;
      n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL flush_early: wr_valid=%b before edge, required 1", wr_valid); end
      @(posedge clock);
      #1;
      flush = 1'b0;
      n_checks++; if (wr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wr_valid: got %b, required 0", wr_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b, required 1", in_ready); end
      n_checks++; if (bundles_done !== '0) begin n_fail++; $display("FAIL flush_done: got %0d, required 0", bundles_done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b, required 0", busy); end
      n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL flush_addr: got %0d, required 0", wr_addr); end
      clear_model();
      wr_ready = 1'b1;
      push_bundle(rand_bundle(), w);
      wait_idle(50);
      n_checks++; if (bundles_done !== exp_done) begin n_fail++; $display("FAIL flush_after_done: got %0d, required %0d", bundles_done, exp_done); end
   endtask

   task automatic test_full_pop_push();
      int w;
      int base = n_acc;
      logic [BW-1:0] c = rand_bundle();
      push_bundle(rand_bundle(), w);
      push_bundle(rand_bundle(), w);
      wait_accepts(base, WB_LANES);
      // final lane of the head is accepted on the coming edge while full
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_pre: in_ready=%b, required 0", in_ready); end
      in_valid = 1'b1;
      in_data  = c;
      @(posedge clock);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_rise: in_ready=%b, required 1", in_ready); end
      enqueue_exp(c);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_refill: in_ready=%b, required 0", in_ready); end
      wait_idle(100);
      n_checks++; if (bundles_done !== exp_done) begin n_fail++; $display("FAIL fullpop_done: got %0d, required %0d", bundles_done, exp_done); end
   endtask

   task automatic test_push_on_pop();
      int w;
      int base = n_acc;
      logic [BW-1:0] b = rand_bundle();
      push_bundle(rand_bundle(), w);
      wait_accepts(base, WB_LANES);
      in_valid = 1'b1;
      in_data  = b;
      enqueue_exp(b);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      n_checks++; if (wr_valid !== 1'b1) begin n_fail++; $display("FAIL pushpop_continue: wr_valid=%b, required 1", wr_valid); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL pushpop_in_ready: got %b, required 1", in_ready); end
      wait_idle(50);
      n_checks++; if (bundles_done !== exp_done) begin n_fail++; $display("FAIL pushpop_done: got %0d, required %0d", bundles_done, exp_done); end
   endtask

   // ---------------- sequence ----------------
   initial begin
      n_checks   = 0;
      n_fail     = 0;
      n_acc      = 0;
      n_holds    = 0;
      held_valid = 1'b0;
      have_last  = 1'b0;
      saw_wrap   = 1'b0;
      last_addr  = '0;
      stall_done = 1'b0;
      reset      = 1'b1;
      flush      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      wr_ready   = 1'b1;
      clear_model();

      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_addr_wrap();
      test_reset_mid();
      test_full_pop_push();
      test_push_on_pop();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
